lcd_reader: RTL and testbench

LCD_READER -- requirements
Module: lcd_reader

---
 rtl/lcd_reader_if.sv | 19 +
 rtl/lcd_reader.sv | 220 ++++++++++++++++++++++
 tb/tb_lcd_reader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_reader_if.sv
// HD44780 pad bundle between the readback controller (master) and the LCD side (slave).
interface lcd_reader_if;
    logic [7:0] LCD_DATA_IN;
    logic [7:0] LCD_DATA_OUT;
    logic       LCD_DATA_OE;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;

    modport master (
        input  LCD_DATA_IN,
        output LCD_DATA_OUT, LCD_DATA_OE, LCD_RS, LCD_RW, LCD_EN
    );

    modport slave (
        output LCD_DATA_IN,
        input  LCD_DATA_OUT, LCD_DATA_OE, LCD_RS, LCD_RW, LCD_EN
    );
endinterface

// File: rtl/lcd_reader.sv
// Reads back a 2x16 HD44780 display through busy-polled SETUP/STROBE/HOLD bus cycles.
// Optional macro LCD_READER_TIMEOUT_EN bounds each busy poll at BUSY_MAX+1 samples.
module lcd_reader #(
    parameter int TICK_DIV = 50,
    parameter int BUSY_MAX = 255
) (
    input  logic           clock,
    input  logic           rst,
    input  logic           start,
    lcd_reader_if.master   lcd,
    output logic           busy,
    output logic           done,
    output logic           timeout,
    output logic [255:0]   data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_CMD,
        S_RD,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    state_t         state_q, state_d;
    phase_t         phase_q, phase_d;
    logic [15:0]    tick_q, tick_d;
    logic [3:0]     char_q, char_d;
    logic           line_q, line_d;
    logic           cmd_pend_q, cmd_pend_d;
    logic           flag_q, flag_d;
    logic [255:0]   shadow_q, shadow_d;
    logic [255:0]   data_q, data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           timeout_q, timeout_d;

`ifdef LCD_READER_TIMEOUT_EN
    localparam logic [15:0] POLL_LAST = 16'(BUSY_MAX);
    logic [15:0]    poll_cnt_q, poll_cnt_d;
`else
    // BUSY_MAX only matters in the timeout build.
    logic           unused_busy_max;
    assign unused_busy_max = (BUSY_MAX != 0);
`endif

    logic           on_bus;
    logic           phase_end;
    logic [7:0]     wr_base;

    assign on_bus    = (state_q == S_POLL) || (state_q == S_CMD) || (state_q == S_RD);
    assign phase_end = (tick_q == TICK_LAST);
    // Line 1 fills [255:128], line 2 [127:0], leftmost character in the top byte.
    assign wr_base   = 8'd255 - {line_q, char_q, 3'b000};

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        tick_d     = tick_q;
        char_d     = char_q;
        line_d     = line_q;
        cmd_pend_d = cmd_pend_q;
        flag_d     = flag_q;
        shadow_d   = shadow_q;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
`ifdef LCD_READER_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_POLL;
                    phase_d    = PH_SETUP;
                    tick_d     = '0;
                    char_d     = '0;
                    line_d     = 1'b0;
                    cmd_pend_d = 1'b1;
                    busy_d     = 1'b1;
`ifdef LCD_READER_TIMEOUT_EN
                    poll_cnt_d = '0;
`endif
                end
            end

            S_POLL, S_CMD, S_RD: begin
                if (!phase_end) begin
                    tick_d = tick_q + 16'd1;
                end else begin
                    tick_d = '0;
                    case (phase_q)
                        PH_SETUP: phase_d = PH_STROBE;
                        PH_STROBE: begin
                            phase_d = PH_HOLD;
                            if (state_q == S_POLL) flag_d = lcd.LCD_DATA_IN[7];
                            if (state_q == S_RD)   shadow_d[wr_base -: 8] = lcd.LCD_DATA_IN;
                        end
                        default: begin
                            phase_d = PH_SETUP;
                            case (state_q)
                                S_POLL: begin
                                    if (flag_q) begin
`ifdef LCD_READER_TIMEOUT_EN
                                        if (poll_cnt_q == POLL_LAST) begin
                                            state_d   = S_ERR;
                                            timeout_d = 1'b1;
                                            busy_d    = 1'b0;
                                        end else begin
                                            poll_cnt_d = poll_cnt_q + 16'd1;
                                        end
`else
                                        state_d = S_POLL;
`endif
                                    end else begin
`ifdef LCD_READER_TIMEOUT_EN
                                        poll_cnt_d = '0;
`endif
                                        state_d = cmd_pend_q ? S_CMD : S_RD;
                                    end
                                end
                                S_CMD: begin
                                    cmd_pend_d = 1'b0;
                                    state_d    = S_POLL;
                                end
                                default: begin
                                    // End of an RD: advance the cursor, re-address at the line wrap.
                                    if (char_q == 4'd15) begin
                                        if (!line_q) begin
                                            line_d     = 1'b1;
                                            char_d     = '0;
                                            cmd_pend_d = 1'b1;
                                            state_d    = S_POLL;
                                        end else begin
                                            state_d = S_DONE;
                                            done_d  = 1'b1;
                                            busy_d  = 1'b0;
                                            data_d  = shadow_q;
                                        end
                                    end else begin
                                        char_d  = char_q + 4'd1;
                                        state_d = S_POLL;
                                    end
                                end
                            endcase
                        end
                    endcase
                end
            end

            default: begin
                state_d = S_IDLE;
                phase_d = PH_SETUP;
                tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_SETUP;
            tick_q     <= '0;
            char_q     <= '0;
            line_q     <= 1'b0;
            cmd_pend_q <= 1'b0;
            flag_q     <= 1'b0;
            shadow_q   <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef LCD_READER_TIMEOUT_EN
            poll_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            tick_q     <= tick_d;
            char_q     <= char_d;
            line_q     <= line_d;
            cmd_pend_q <= cmd_pend_d;
            flag_q     <= flag_d;
            shadow_q   <= shadow_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
`ifdef LCD_READER_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
`endif
        end
    end

    // Pads decode straight from the state flops, so reset drops EN without waiting for a clock.
    always_comb begin
        lcd.LCD_EN       = on_bus && (phase_q == PH_STROBE);
        lcd.LCD_RS       = (state_q == S_RD);
        lcd.LCD_RW       = (state_q == S_POLL) || (state_q == S_RD);
        lcd.LCD_DATA_OE  = (state_q == S_CMD);
        lcd.LCD_DATA_OUT = (state_q == S_CMD) ? (line_q ? 8'hC0 : 8'h80) : 8'h00;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign data    = data_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Bench for lcd_reader: HD44780 RAM/address-counter model on the pads, scoreboard of readbacks.
module tb_lcd_reader;
    localparam int TD = 4;
    localparam int BM = 5;

    logic         clock = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic         busy, done, timeout;
    logic [255:0] data;

    lcd_reader_if lcd ();

    lcd_reader #(.TICK_DIV(TD), .BUSY_MAX(BM)) dut (
        .clock   (clock),
        .rst     (rst),
        .start   (start),
        .lcd     (lcd),
        .busy    (busy),
        .done    (done),
        .timeout (timeout),
        .data    (data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [255:0] data;
        int           polls;
        int           cmds;
        int           rds;
        int           pre;
        bit           tmo;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // LCD model: 128-byte DDRAM, auto-incrementing address, scripted busy answers per poll slot.
    logic [7:0] ram [0:127];
    logic [6:0] addr = '0;
    bit         stuck = 1'b0;
    int         busy_sched [0:63];
    int         slot = 0;
    int         used = 0;
    logic       busy_now;

    assign busy_now = stuck || ((slot < 64) && (used < busy_sched[slot]));
    assign lcd.LCD_DATA_IN = !lcd.LCD_RW ? 8'h00 : (lcd.LCD_RS ? ram[addr] : {busy_now, addr});

    // Monitor: bus strobe accounting, timing checks and scoreboard pops.
    int   n_poll, n_cmd, n_rd, pre, en_len, en_low, end_seen, tmo_seen;
    logic en_prev = 1'b0, busy_prev = 1'b0, done_prev = 1'b0, tmo_prev = 1'b0;
    exp_t e;

    initial begin
        n_poll = 0; n_cmd = 0; n_rd = 0; pre = -1;
        en_len = 0; en_low = 0; end_seen = 0; tmo_seen = 0;
    end

    always @(negedge clock) begin
        if (!rst) begin
            en_prev = 1'b0; busy_prev = 1'b0; done_prev = 1'b0; tmo_prev = 1'b0;
        end else begin
            if (busy && !busy_prev) begin
                n_poll = 0; n_cmd = 0; n_rd = 0; pre = -1;
                en_low = 1; slot = 0; used = 0;
            end else if (lcd.LCD_EN && !en_prev) begin
                check("en_gap", en_low, (n_poll + n_cmd + n_rd == 0) ? TD : 2 * TD);
                en_len = 1;
                if (!lcd.LCD_RW) begin
                    n_cmd++;
                    if (pre < 0) pre = n_poll;
                    check("oe_write", lcd.LCD_DATA_OE, 1'b1);
                end else begin
                    check("oe_read", lcd.LCD_DATA_OE, 1'b0);
                    if (lcd.LCD_RS) n_rd++;
                    else n_poll++;
                end
            end else if (lcd.LCD_EN) begin
                en_len++;
            end else if (en_prev) begin
                check("en_width", en_len, TD);
                if (lcd.LCD_RW && !lcd.LCD_RS) begin
                    if (busy_now) used++;
                    else begin slot++; used = 0; end
                end else if (lcd.LCD_RW) begin
                    addr = addr + 7'd1;
                end else if (lcd.LCD_DATA_OUT[7]) begin
                    addr = lcd.LCD_DATA_OUT[6:0];
                end
                en_low = 1;
            end else begin
                en_low++;
            end

            if (done || timeout) begin
                end_seen++;
                if (timeout) tmo_seen++;
                check("end_delay", en_low, TD + 1);
                check("busy_fall", {busy_prev, busy}, 2'b10);
                if (sb.size() == 0) begin
                    check("unexpected_end", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("end_kind", {done, timeout}, {!e.tmo, e.tmo});
                    check("data", data, e.data);
                    check("polls", n_poll, e.polls);
                    check("cmds", n_cmd, e.cmds);
                    check("rds", n_rd, e.rds);
                    check("polls_before_cmd", pre, e.pre);
                end
            end
            if (done_prev) check("done_width", done, 1'b0);
            if (tmo_prev)  check("timeout_width", timeout, 1'b0);
            en_prev = lcd.LCD_EN; busy_prev = busy; done_prev = done; tmo_prev = timeout;
        end
    end

    // Stimulus side and reference expectations.
    logic [255:0] last_data = '0;

    task automatic load_line(input int base, input string s);
        for (int c = 0; c < 16; c++) ram[base + c] = s[c];
    endtask

    task automatic rand_screen();
        for (int c = 0; c < 16; c++) begin
            ram[c]      = 8'($urandom_range(32, 126));
            ram[64 + c] = 8'($urandom_range(32, 126));
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 64; i++) busy_sched[i] = 0;
    endtask

    function automatic exp_t expect_read();
        exp_t x;
        int   extra = 0;
        for (int c = 0; c < 16; c++) begin
            x.data[255 - 8 * c -: 8] = ram[c];
            x.data[127 - 8 * c -: 8] = ram[64 + c];
        end
        for (int i = 0; i < 34; i++) extra += busy_sched[i];
        x.polls = 34 + extra;
        x.cmds  = 2;
        x.rds   = 32;
        x.pre   = busy_sched[0] + 1;
        x.tmo   = 1'b0;
        return x;
    endfunction

    task automatic issue(input exp_t x);
        sb.push_back(x);
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        check("busy_rise", busy, 1'b1);
    endtask

    task automatic wait_end();
        int k = 0;
        do begin @(negedge clock); k++; end while (!(done || timeout) && k < 5000);
        if (k >= 5000) check("end_wait_budget", 1'b0, 1'b1);
    endtask

    task automatic wait_rd(input int n, input bit need_en);
        int k = 0;
        do begin @(negedge clock); #1; k++; end
        while (!(n_rd == n && (!need_en || lcd.LCD_EN)) && k < 5000);
        if (k >= 5000) check("rd_wait_budget", 1'b0, 1'b1);
    endtask

    task automatic full_read();
        exp_t x;
        x = expect_read();
        issue(x);
        wait_end();
        last_data = x.data;
    endtask

    initial begin
        clear_sched();
        for (int i = 0; i < 128; i++) ram[i] = 8'h20;

        repeat (3) @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_data", data, '0);
        check("rst_en", lcd.LCD_EN, 1'b0);
        check("rst_rs_rw", {lcd.LCD_RS, lcd.LCD_RW}, 2'b00);
        check("rst_oe", lcd.LCD_DATA_OE, 1'b0);
        check("rst_dout", lcd.LCD_DATA_OUT, 8'h00);
        rst = 1'b1;
        repeat (6) @(negedge clock);
        check("idle_wait", {busy, lcd.LCD_EN}, 2'b00);

        // Fixed screen, no busy answers.
        load_line(0, "HELLO WORLD     ");
        load_line(64, "FPGA LCD TEST   ");
        full_read();
        check("first_char", data[255:248], 8'h48);
        check("last_char", data[7:0], 8'h20);

        // Three busy answers before the first command.
        busy_sched[0] = 3;
        full_read();
        check("busy3_data_line2", data[127:120], 8'h46);
        clear_sched();

        // Random screens with random busy answers on random slots.
        for (int r = 0; r < 3; r++) begin
            rand_screen();
            for (int i = 0; i < 34; i++) busy_sched[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            full_read();
        end
        clear_sched();

        // Restart attempts while busy and in the done cycle are ignored.
        rand_screen();
        begin
            exp_t x;
            x = expect_read();
            issue(x);
            wait_rd(10, 1'b0);
            start = 1'b1;
            @(negedge clock); start = 1'b0;
            wait_end();
            last_data = x.data;
        end
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        check("done_cycle_start_busy", busy, 1'b0);
        repeat (20) @(negedge clock);
        check("done_cycle_start_idle", {busy, lcd.LCD_EN}, 2'b00);

        // Reset during an RD strobe aborts and clears the readout.
        rand_screen();
        begin
            exp_t x;
            x = expect_read();
            issue(x);
            wait_rd(21, 1'b1);
            rst = 1'b0;
            #1;
            check("abort_en", lcd.LCD_EN, 1'b0);
            check("abort_data", data, '0);
            check("abort_busy", busy, 1'b0);
            sb.delete();
            last_data = '0;
            repeat (4) @(negedge clock);
            check("abort_en_held", lcd.LCD_EN, 1'b0);
            rst = 1'b1;
        end
        rand_screen();
        full_read();

`ifdef LCD_READER_TIMEOUT_EN
        // Stuck busy flag: BUSY_MAX+1 polls, then timeout with the old readout kept.
        begin
            exp_t x;
            x.data = last_data; x.polls = BM + 1; x.cmds = 0; x.rds = 0; x.pre = -1; x.tmo = 1'b1;
            stuck = 1'b1;
            issue(x);
            wait_end();
            stuck = 1'b0;
            @(negedge clock);
            check("tmo_data_kept", data, last_data);
        end
        rand_screen();
        full_read();
`else
        check("no_timeout_pulses", tmo_seen, 0);
`endif

        repeat (4) @(negedge clock);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
